arc_kbd_proto: RTL and testbench
================================

Name: arc_kbd_proto

Overview:
- Emulates the Archimedes keyboard's serial-protocol controller at byte level.
- Sits directly upstream of the IOC keyboard port: its tx byte/strobe drive the IOC kbd_in pair, and it consumes the IOC kbd_out pair.
- Key make/break events from the IO-controller key source are queued, then sent as two-byte KDDA/KUDA packets under the HRST/RAK1/RAK2 reset handshake and the BACK/SACK/NACK/SMAK/MACK flow control.

Parameters:
- FIFO_DEPTH, 8, key event queue depth (power of two, 2..32).
- TX_GAP, 400, minimum clkcpu cycles between tx strobes; lets IOC serial emulation drain.
- KBD_ID, 1, 6-bit keyboard ID returned as 0x80|KBD_ID on RQID.

Ports:
- clkcpu  in  1  system clock (all logic on rising edge).
- rst_n  in  1  asynchronous active-low reset.
- key_valid  in  1  one-cycle pulse: new key event.
- key_code  in  8  row = [7:4], column = [3:0].
- key_up  in  1  1 = break (KUDA), 0 = make (KDDA); sampled with key_valid.
- rx_data  in  8  byte from IOC (host command).
- rx_strobe  in  1  one-cycle pulse, rx_data valid.
- tx_data  out  8  byte to IOC; held until next strobe.
- tx_strobe  out  1  one-cycle pulse, tx_data valid.
- leds  out  3  LEDS command bits [2:0] (caps, num, scroll).
- fifo_ovf  out  1  one-cycle pulse when an event is dropped.

Behaviour:
- Reset values: tx_data = 0x00, tx_strobe = 0, leds = 0, fifo_ovf = 0, FIFO empty, key_en = 0, gap counter = 0, state = S_PWRUP.
- Tx engine:
  - A tx is issued only when the gap counter is 0; issuing loads the counter with TX_GAP.
  - A byte pending while the gap is nonzero waits; at most one pending byte.
  - Response latency: 1 cycle after rx_strobe if gap = 0, else on the first cycle gap reaches 0.
- Host commands:
  - HRST 0xFF, RAK1 0xFE, RAK2 0xFD, BACK 0x3F, NACK 0x30, SACK 0x31, MACK 0x32, SMAK 0x33.
  - RQID 0x20, PRST 0x21, LEDS 0x00-0x07.
- States:
  - S_PWRUP: send HRST 0xFF once -> S_WAIT_HRST.
  - S_WAIT_HRST: rx HRST -> send 0xFF, -> S_WAIT_RAK1; other bytes ignored.
  - S_WAIT_RAK1: rx RAK1 -> send 0xFE, -> S_WAIT_RAK2; any other byte except HRST -> send 0xFF, -> S_WAIT_HRST.
  - S_WAIT_RAK2: rx RAK2 -> send 0xFD, -> S_IDLE; any other byte except HRST -> send 0xFF, -> S_WAIT_HRST.
  - S_IDLE:
    - SACK/SMAK set key_en; NACK/MACK clear it.
    - LEDS loads leds = rx[2:0]; RQID sends 0x80|KBD_ID; PRST and BACK are ignored.
    - If key_en = 1, FIFO nonempty and tx free: send byte1 = {KDDA 0xC | KUDA 0xD, row}, -> S_WAIT_BACK.
  - S_WAIT_BACK: rx BACK -> send byte2 = {same prefix, col}, -> S_WAIT_ACK; other bytes ignored (except HRST, LEDS, RQID handled as in S_IDLE).
  - S_WAIT_ACK: SACK/SMAK -> pop FIFO, key_en = 1, -> S_IDLE; NACK/MACK -> pop FIFO, key_en = 0, -> S_IDLE.
  - HRST in any state: send 0xFF, flush FIFO, key_en = 0, -> S_WAIT_RAK1. This takes priority over a same-cycle key_valid.
- FIFO:
  - Entry = {key_up, key_code} (9 bits).
  - Push on key_valid accepted in every state except during the HRST flush cycle.
  - Full + push: event dropped, fifo_ovf pulses.
  - Simultaneous push and pop when full: push accepted.
  - Pointer wrap is modulo FIFO_DEPTH.
  - The head entry is popped only on the final ack, so a key resent after HRST is lost (flushed) by design.
- No timeouts; a host that never acks stalls key delivery but keyboard events keep queueing.

Optional Feature:
- Macro ARC_KBD_MOUSE_EN.
- When defined:
  - Adds inputs mouse_valid (1 bit), mouse_dx and mouse_dy (8-bit signed), accumulated into saturating ±63 registers.
  - Adds a mouse_en flag, set by SMAK/MACK and cleared by SACK/NACK.
  - In S_IDLE with mouse_en, FIFO empty and a nonzero accumulator: send {0, dx[6:0]}, wait BACK, send {0, dy[6:0]}, wait ack. The accumulators are cleared when the packet is latched.
  - Key packets have priority over mouse packets.
- When undefined: no mouse ports; SMAK behaves as SACK and MACK as NACK for key_en purposes only.

Test Plan:
- Reset release -> tx 0xFF; host 0xFF, 0xFE, 0xFD each answered with the same byte; each tx ≥ TX_GAP cycles after the previous one.
- After handshake, host SACK; key_valid code 0x5A make -> tx 0xC5; host BACK -> tx 0xCA; host SACK -> FIFO empty.
- key_en = 0 (NACK) with key 0x12 break queued -> no tx; host SACK -> tx 0xD1, BACK -> 0xD2.
- Push 9 events with FIFO_DEPTH = 8 while key_en = 0 -> exactly one fifo_ovf pulse, first 8 delivered in order.
- Host HRST while in S_WAIT_BACK -> tx 0xFF, FIFO flushed; host RAK1 -> 0xFE.
- LEDS 0x05 -> leds = 3'b101; RQID -> tx 0x81; rst_n asserted mid-packet -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/arc_kbd_proto.sv
// Archimedes keyboard serial-protocol controller: reset handshake, key event queue, paced byte tx.
// Define ARC_KBD_MOUSE_EN to add mouse accumulators and mouse packets.
module arc_kbd_proto #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         TX_GAP     = 400,
  parameter logic [5:0] KBD_ID     = 6'd1
) (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_up,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe,
  output logic [7:0] tx_data,
  output logic       tx_strobe,
  output logic [2:0] leds,
  output logic       fifo_ovf
`ifdef ARC_KBD_MOUSE_EN
  ,
  input  logic       mouse_valid,
  input  logic [7:0] mouse_dx,
  input  logic [7:0] mouse_dy
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (TX_GAP < 2) ? 1 : $clog2(TX_GAP + 1);

  localparam logic [7:0] HRST = 8'hFF, RAK1 = 8'hFE, RAK2 = 8'hFD, BACK = 8'h3F;
  localparam logic [7:0] NACK = 8'h30, SACK = 8'h31, MACK = 8'h32, SMAK = 8'h33, RQID = 8'h20;

  typedef enum logic [2:0] {
    S_PWRUP, S_WAIT_HRST, S_WAIT_RAK1, S_WAIT_RAK2, S_IDLE, S_WAIT_BACK, S_WAIT_ACK
  } state_t;

  state_t state, state_n;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [8:0]    head;
  logic          fifo_empty, fifo_full, push_req, push_ok, pop, flush;

  logic          pend_valid;
  logic [7:0]    pend_data;
  logic [GW-1:0] gap;
  logic          tx_free, send_req;
  logic [7:0]    send_byte;

  logic          key_en, key_en_n;
  logic [2:0]    leds_n;
  logic [7:0]    pkt_byte2;
  logic          pkt_mouse, latch_key, latch_mouse;
  logic          is_en_cmd, is_dis_cmd, is_leds;

`ifdef ARC_KBD_MOUSE_EN
  logic          mouse_en, mouse_en_n;
  logic [6:0]    acc_dx, acc_dy;

  function automatic logic [6:0] sat_add(input logic [6:0] acc, input logic [7:0] d);
    logic signed [8:0] s;
    s = $signed({{2{acc[6]}}, acc}) + $signed({d[7], d});
    if (s > 9'sd63) return 7'h3F;
    if (s < -9'sd63) return 7'h41;
    return s[6:0];
  endfunction
`endif

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign push_req   = key_valid && !flush;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign tx_free    = (gap == '0) && !pend_valid;
  assign is_en_cmd  = (rx_data == SACK) || (rx_data == SMAK);
  assign is_dis_cmd = (rx_data == NACK) || (rx_data == MACK);
  assign is_leds    = (rx_data[7:3] == 5'd0);

  // HRST from the host overrides whatever the protocol was doing.
  always_comb begin
    state_n     = state;
    send_req    = 1'b0;
    send_byte   = 8'h00;
    key_en_n    = key_en;
    leds_n      = leds;
    pop         = 1'b0;
    flush       = 1'b0;
    latch_key   = 1'b0;
    latch_mouse = 1'b0;
`ifdef ARC_KBD_MOUSE_EN
    mouse_en_n  = mouse_en;
`endif
    if (rx_strobe && rx_data == HRST) begin
      send_req  = 1'b1;
      send_byte = HRST;
      flush     = 1'b1;
      key_en_n  = 1'b0;
`ifdef ARC_KBD_MOUSE_EN
      mouse_en_n = 1'b0;
`endif
      state_n   = S_WAIT_RAK1;
    end else begin
      case (state)
        S_PWRUP: begin
          send_req  = 1'b1;
          send_byte = HRST;
          state_n   = S_WAIT_HRST;
        end
        S_WAIT_HRST: ;
        S_WAIT_RAK1: if (rx_strobe) begin
          send_req = 1'b1;
          if (rx_data == RAK1) begin
            send_byte = RAK1;
            state_n   = S_WAIT_RAK2;
          end else begin
            send_byte = HRST;
            state_n   = S_WAIT_HRST;
          end
        end
        S_WAIT_RAK2: if (rx_strobe) begin
          send_req = 1'b1;
          if (rx_data == RAK2) begin
            send_byte = RAK2;
            state_n   = S_IDLE;
          end else begin
            send_byte = HRST;
            state_n   = S_WAIT_HRST;
          end
        end
        S_IDLE: begin
          if (rx_strobe) begin
            if (is_en_cmd) key_en_n = 1'b1;
            else if (is_dis_cmd) key_en_n = 1'b0;
            else if (rx_data == RQID) begin
              send_req  = 1'b1;
              send_byte = {2'b10, KBD_ID};
            end else if (is_leds) leds_n = rx_data[2:0];
`ifdef ARC_KBD_MOUSE_EN
            if (rx_data == SMAK || rx_data == MACK) mouse_en_n = 1'b1;
            else if (rx_data == SACK || rx_data == NACK) mouse_en_n = 1'b0;
`endif
          end
          // A same-cycle host response wins; keys wait for the next free slot.
          if (!send_req && tx_free) begin
            if (key_en_n && !fifo_empty) begin
              send_req  = 1'b1;
              send_byte = {(head[8] ? 4'hD : 4'hC), head[7:4]};
              latch_key = 1'b1;
              state_n   = S_WAIT_BACK;
            end
`ifdef ARC_KBD_MOUSE_EN
            else if (mouse_en_n && fifo_empty && (acc_dx != '0 || acc_dy != '0)) begin
              send_req    = 1'b1;
              send_byte   = {1'b0, acc_dx};
              latch_mouse = 1'b1;
              state_n     = S_WAIT_BACK;
            end
`endif
          end
        end
        S_WAIT_BACK: if (rx_strobe) begin
          if (rx_data == BACK) begin
            send_req  = 1'b1;
            send_byte = pkt_byte2;
            state_n   = S_WAIT_ACK;
          end else if (rx_data == RQID) begin
            send_req  = 1'b1;
            send_byte = {2'b10, KBD_ID};
          end else if (is_leds) leds_n = rx_data[2:0];
        end
        S_WAIT_ACK: if (rx_strobe && (is_en_cmd || is_dis_cmd)) begin
          pop      = !pkt_mouse;
          key_en_n = is_en_cmd;
`ifdef ARC_KBD_MOUSE_EN
          mouse_en_n = (rx_data == SMAK) || (rx_data == MACK);
`endif
          state_n  = S_IDLE;
        end
        default: state_n = S_PWRUP;
      endcase
    end
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PWRUP;
      key_en    <= 1'b0;
      leds      <= 3'd0;
      pkt_byte2 <= 8'h00;
      pkt_mouse <= 1'b0;
    end else begin
      state  <= state_n;
      key_en <= key_en_n;
      leds   <= leds_n;
      if (latch_key) begin
        pkt_byte2 <= {(head[8] ? 4'hD : 4'hC), head[3:0]};
        pkt_mouse <= 1'b0;
      end
`ifdef ARC_KBD_MOUSE_EN
      else if (latch_mouse) begin
        pkt_byte2 <= {1'b0, acc_dy};
        pkt_mouse <= 1'b1;
      end
`endif
    end
  end

  // Tx pacing: one byte may wait in pend_* until the gap counter drains.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= 8'h00;
      tx_strobe  <= 1'b0;
      pend_valid <= 1'b0;
      pend_data  <= 8'h00;
      gap        <= '0;
    end else begin
      tx_strobe <= 1'b0;
      if (gap != '0) gap <= gap - 1'b1;
      if (gap == '0 && pend_valid) begin
        tx_data    <= pend_data;
        tx_strobe  <= 1'b1;
        gap        <= GW'(TX_GAP);
        pend_valid <= send_req;
        if (send_req) pend_data <= send_byte;
      end else if (gap == '0 && send_req) begin
        tx_data   <= send_byte;
        tx_strobe <= 1'b1;
        gap       <= GW'(TX_GAP);
      end else if (send_req) begin
        pend_valid <= 1'b1;
        pend_data  <= send_byte;
      end
    end
  end

  always_ff @(posedge clkcpu) begin
    if (push_ok) fifo_mem[wr_ptr] <= {key_up, key_code};
  end

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      fifo_ovf <= 1'b0;
    end else begin
      fifo_ovf <= push_req && fifo_full && !pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push_ok && !pop) count <= count + 1'b1;
        else if (pop && !push_ok) count <= count - 1'b1;
      end
    end
  end

`ifdef ARC_KBD_MOUSE_EN
  // Motion arriving in the latch cycle starts the next accumulation from zero.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      mouse_en <= 1'b0;
      acc_dx   <= '0;
      acc_dy   <= '0;
    end else begin
      mouse_en <= mouse_en_n;
      if (mouse_valid) begin
        acc_dx <= sat_add(latch_mouse ? 7'd0 : acc_dx, mouse_dx);
        acc_dy <= sat_add(latch_mouse ? 7'd0 : acc_dy, mouse_dy);
      end else if (latch_mouse) begin
        acc_dx <= '0;
        acc_dy <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arc_kbd_proto.sv
// Scoreboard bench for arc_kbd_proto (default build): a queue-based host/keyboard model
// predicts every tx byte, and a monitor checks bytes, spacing and overflow pulses.
`timescale 1ns/1ps
module tb_arc_kbd_proto;

  localparam int         FIFO_DEPTH = 8;
  localparam int         TX_GAP     = 16;
  localparam logic [5:0] KBD_ID     = 6'd1;

  localparam logic [7:0] HRST = 8'hFF, RAK1 = 8'hFE, RAK2 = 8'hFD, BACK = 8'h3F;
  localparam logic [7:0] NACK = 8'h30, SACK = 8'h31, MACK = 8'h32, SMAK = 8'h33;
  localparam logic [7:0] RQID = 8'h20, PRST = 8'h21;

  logic       clkcpu = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_up = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_strobe = 1'b0;
  logic [7:0] tx_data;
  logic       tx_strobe;
  logic [2:0] leds;
  logic       fifo_ovf;

  arc_kbd_proto #(.FIFO_DEPTH(FIFO_DEPTH), .TX_GAP(TX_GAP), .KBD_ID(KBD_ID)) dut (
    .clkcpu(clkcpu), .rst_n(rst_n),
    .key_valid(key_valid), .key_code(key_code), .key_up(key_up),
    .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_data(tx_data), .tx_strobe(tx_strobe),
    .leds(leds), .fifo_ovf(fifo_ovf)
  );

  always #5 clkcpu = ~clkcpu;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  int         exp_total = 0;
  int         tx_seen = 0;
  int         ovf_seen = 0;
  int         exp_ovf = 0;
  int         cyc = 0;
  int         last_cyc = 0;
  bit         last_valid = 1'b0;

  // Host-view model: queued key events, key enable, and whether a packet is in flight.
  logic [8:0] mq[$];
  bit         m_key_en = 1'b0;
  bit         m_busy = 1'b0;

  function automatic logic [7:0] byte1(input logic [8:0] e);
    return (e[8] ? 8'hD0 : 8'hC0) + 8'(e[7:4]);
  endfunction

  function automatic logic [7:0] byte2(input logic [8:0] e);
    return (e[8] ? 8'hD0 : 8'hC0) + 8'(e[3:0]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, required);
    end
  endtask

  task automatic applyStimulus(input bit is_key, input logic [8:0] val);
    @(negedge clkcpu);
    if (is_key) begin
      key_valid = 1'b1;
      key_up    = val[8];
      key_code  = val[7:0];
    end else begin
      rx_strobe = 1'b1;
      rx_data   = val[7:0];
    end
    @(negedge clkcpu);
    key_valid = 1'b0;
    rx_strobe = 1'b0;
  endtask

  task automatic expectTx(input logic [7:0] b);
    exp_q.push_back(b);
    exp_total++;
  endtask

  task automatic waitAllTx(input string name);
    int n;
    n = 0;
    while (tx_seen < exp_total && n < 6 * TX_GAP + 40) begin
      @(negedge clkcpu);
      #1;
      n++;
    end
    checkOutput(name, tx_seen, exp_total);
    if (tx_seen != exp_total) begin
      exp_q.delete();
      exp_total = tx_seen;
    end
  endtask

  task automatic waitQuiet(input string name, input int n);
    repeat (n) @(negedge clkcpu);
    #1;
    checkOutput(name, tx_seen, exp_total);
  endtask

  task automatic kick();
    if (!m_busy && m_key_en && mq.size() > 0) begin
      expectTx(byte1(mq[0]));
      m_busy = 1'b1;
    end
  endtask

  task automatic pushKey(input logic [8:0] e);
    if (mq.size() >= FIFO_DEPTH) exp_ovf++;
    else mq.push_back(e);
    kick();
    applyStimulus(1'b1, e);
  endtask

  task automatic hostEnable(input logic [7:0] cmd);
    m_key_en = (cmd == SACK) || (cmd == SMAK);
    kick();
    applyStimulus(1'b0, {1'b0, cmd});
  endtask

  task automatic hostReply(input logic [7:0] cmd, input logic [7:0] resp, input string name);
    expectTx(resp);
    applyStimulus(1'b0, {1'b0, cmd});
    waitAllTx(name);
  endtask

  task automatic deliverHead(input logic [7:0] ack);
    logic [8:0] e;
    waitAllTx("byte1_seen");
    if (mq.size() == 0) return;
    e = mq[0];
    expectTx(byte2(e));
    applyStimulus(1'b0, {1'b0, BACK});
    waitAllTx("byte2_seen");
    e = mq.pop_front();
    m_busy   = 1'b0;
    m_key_en = (ack == SACK) || (ack == SMAK);
    kick();
    applyStimulus(1'b0, {1'b0, ack});
  endtask

  task automatic hostHrst();
    mq.delete();
    m_busy   = 1'b0;
    m_key_en = 1'b0;
    hostReply(HRST, HRST, "hrst_echo");
  endtask

  // Monitor: every tx strobe is matched against the scoreboard and its spacing checked.
  always @(negedge clkcpu) begin
    logic [7:0] eb;
    cyc++;
    if (rst_n && tx_strobe) begin
      tx_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_tx: got 0x%0h expected none", tx_data);
      end else begin
        eb = exp_q.pop_front();
        checkOutput("tx_byte", tx_data, eb);
      end
      if (last_valid) checkOutput("tx_gap_ok", 32'((cyc - last_cyc) >= TX_GAP), 32'd1);
      last_cyc   = cyc;
      last_valid = 1'b1;
    end
    if (rst_n && fifo_ovf) ovf_seen++;
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clkcpu);
    checkOutput("rst_tx_data", tx_data, 8'h00);
    checkOutput("rst_tx_strobe", tx_strobe, 1'b0);
    checkOutput("rst_leds", leds, 3'd0);
    checkOutput("rst_fifo_ovf", fifo_ovf, 1'b0);

    // Power-up HRST, then the reset handshake including the retry paths.
    expectTx(HRST);
    rst_n = 1'b1;
    waitAllTx("pwrup_hrst");
    applyStimulus(1'b0, 9'h042);
    waitQuiet("wait_hrst_ignore", 2 * TX_GAP);
    hostReply(HRST, HRST, "hs_hrst1");
    hostReply(8'h55, HRST, "rak1_bad");
    hostReply(HRST, HRST, "hs_hrst2");
    hostReply(RAK1, RAK1, "hs_rak1");
    hostReply(RAK2, RAK2, "hs_rak2");

    // Basic make packet.
    hostEnable(SACK);
    pushKey({1'b0, 8'h5A});
    deliverHead(SACK);
    waitQuiet("fifo_empty_after_ack", 2 * TX_GAP);

    // Break event held back while disabled.
    hostEnable(NACK);
    pushKey({1'b1, 8'h12});
    waitQuiet("nack_hold", 3 * TX_GAP);
    hostEnable(SACK);
    deliverHead(SACK);
    applyStimulus(1'b0, {1'b0, PRST});
    applyStimulus(1'b0, {1'b0, BACK});
    waitQuiet("idle_ignore", 2 * TX_GAP);

    // Overflow: nine events into an eight-deep queue.
    hostEnable(NACK);
    for (int i = 0; i < FIFO_DEPTH + 1; i++) pushKey({1'($urandom_range(0, 1)), 8'(i * 16 + 3 + $urandom_range(0, 9))});
    repeat (3) @(negedge clkcpu);
    checkOutput("ovf_count", ovf_seen, exp_ovf);
    hostEnable(SACK);
    while (mq.size() > 0) deliverHead(SACK);
    waitQuiet("ovf_drained", 2 * TX_GAP);

    // Randomized traffic with mixed acks and LED updates.
    for (int r = 0; r < 10; r++) begin
      int k;
      int sel;
      logic [7:0] ack;
      logic [2:0] v;
      k = $urandom_range(1, 4);
      for (int i = 0; i < k; i++) begin
        pushKey({1'($urandom_range(0, 1)), 8'($urandom)});
        repeat ($urandom_range(0, 3)) @(negedge clkcpu);
      end
      while (mq.size() > 0) begin
        sel = $urandom_range(0, 9);
        ack = (sel < 5) ? SACK : (sel < 8) ? SMAK : (sel == 8) ? NACK : MACK;
        deliverHead(ack);
        if (!m_key_en) begin
          waitQuiet("rand_disabled", 2 * TX_GAP);
          hostEnable(SACK);
        end
      end
      if (r % 3 == 0) begin
        v = 3'($urandom_range(0, 7));
        applyStimulus(1'b0, {6'd0, v});
        checkOutput("leds_rand", leds, v);
      end
    end

    // Commands served while a packet waits for BACK.
    pushKey({1'b0, 8'h37});
    waitAllTx("wb_byte1");
    hostReply(RQID, 8'h80 | 8'(KBD_ID), "wb_rqid");
    applyStimulus(1'b0, 9'h003);
    checkOutput("wb_leds", leds, 3'b011);
    deliverHead(SACK);

    // HRST in the middle of a packet flushes the queue.
    pushKey({1'b1, 8'hE4});
    pushKey({1'b0, 8'h6B});
    waitAllTx("hrst_byte1");
    hostHrst();
    hostReply(RAK1, RAK1, "re_rak1");
    hostReply(RAK2, RAK2, "re_rak2");
    hostEnable(SACK);
    waitQuiet("flushed_quiet", 3 * TX_GAP);
    pushKey({1'b0, 8'h29});
    deliverHead(SACK);

    // LEDS and RQID in idle.
    applyStimulus(1'b0, 9'h005);
    checkOutput("leds_101", leds, 3'b101);
    hostReply(RQID, 8'h81, "rqid");

    // Asynchronous reset mid-packet.
    pushKey({1'b1, 8'hA7});
    waitAllTx("mid_byte1");
    repeat (3) @(negedge clkcpu);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_tx_data", tx_data, 8'h00);
    checkOutput("mid_rst_tx_strobe", tx_strobe, 1'b0);
    checkOutput("mid_rst_leds", leds, 3'd0);
    checkOutput("mid_rst_fifo_ovf", fifo_ovf, 1'b0);
    mq.delete();
    exp_q.delete();
    exp_total  = tx_seen;
    m_busy     = 1'b0;
    m_key_en   = 1'b0;
    last_valid = 1'b0;
    repeat (2) @(negedge clkcpu);
    expectTx(HRST);
    rst_n = 1'b1;
    waitAllTx("post_rst_hrst");
    hostReply(HRST, HRST, "post_hrst");
    hostReply(RAK1, RAK1, "post_rak1");
    hostReply(RAK2, RAK2, "post_rak2");

    repeat (4) @(negedge clkcpu);
    checkOutput("ovf_total", ovf_seen, exp_ovf);
    checkOutput("scoreboard_left", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
